// File: rtl/ctrl_bubble_stage.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_bubble_stage
// Purpose  : ID/EX control pipeline register with self-timed bubble
//            insertion. A hazard request on a valid ID instruction injects
//            1..2^CNT_W-1 all-zero bubbles into EX. PC and IF/ID are stalled
//            while the bubbles go out, and then the held instruction is
//            released once. Flush (taken branch), global hold (downstream
//            stall) and a saturating bubble performance counter are also
//            provided.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - asynchronous, active-low reset
//            ctrl_i       - control bundle from the control unit
//            valid_i      - ID stage holds a real instruction
//            hazard_i     - bubble request for the current ID instruction
//            bubble_len_i - number of bubbles requested (0 behaves as 1)
//            flush_i      - kill ID/EX contents
//            hold_i       - freeze this stage
//            ctrl_o       - registered control bundle to EX
//            valid_o      - registered valid to EX
//            stall_o      - PC / IF/ID write disable (combinational)
//            busy_o       - a bubble sequence is in progress (combinational)
//            bubble_cnt_o - saturating count of inserted bubbles
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_bubble_stage #(
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic              hazard_i,
  input  logic [CNT_W-1:0]  bubble_len_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] bubble_cnt_o
);

  // RUN     : normal pass-through, accepts new bubble requests
  // BUBBLE  : bubbles still being inserted, r_cnt holds how many remain
  // RELEASE : last bubble is out, the held instruction passes on the next edge
  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BUBBLE  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] C_PERF_ONE = PERF_W'(1);
  localparam logic [PERF_W-1:0] C_PERF_MAX = {PERF_W{1'b1}};

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_valid;
  logic [PERF_W-1:0]   r_bcnt;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CTRL_W-1:0]   w_ctrl_nxt;
  logic                w_valid_nxt;
  logic [PERF_W-1:0]   w_bcnt_nxt;
  logic                w_insert;     // this edge puts a bubble into EX
  logic                w_req;        // new bubble request accepted in RUN
  logic [CNT_W-1:0]    w_len;        // effective request length, never 0

  assign w_req = (r_state == S_RUN) && valid_i && hazard_i;
  assign w_len = (bubble_len_i == '0) ? C_CNT_ONE : bubble_len_i;

  // --------------------------------------------------------------------------
  // Next-state / datapath selection.
  // Priority at the edge: flush > hold > state action.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctrl_nxt  = r_ctrl;
    w_valid_nxt = r_valid;
    w_insert    = 1'b0;

    if (flush_i) begin
      // Kill everything, including any pending bubbles; not a bubble itself.
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_ctrl_nxt  = '0;
      w_valid_nxt = 1'b0;
    end else if (hold_i) begin
      // Downstream stall: every register keeps its value.
      w_state_nxt = r_state;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_req) begin
            // First bubble goes out on this edge; r_cnt tracks the rest.
            w_insert    = 1'b1;
            w_ctrl_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = w_len - C_CNT_ONE;
            w_state_nxt = (w_len == C_CNT_ONE) ? S_RELEASE : S_BUBBLE;
          end else begin
            // A hazard without a valid instruction passes straight through.
            w_ctrl_nxt  = ctrl_i;
            w_valid_nxt = valid_i;
          end
        end

        S_BUBBLE: begin
          w_insert    = 1'b1;
          w_ctrl_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
          // <= rather than == so a corrupted zero count cannot lock us here.
          if (r_cnt <= C_CNT_ONE) begin
            w_state_nxt = S_RELEASE;
          end
        end

        S_RELEASE: begin
          // The held instruction passes exactly once; a still-asserted
          // hazard_i is ignored here so it cannot re-trigger bubbles.
          w_ctrl_nxt  = ctrl_i;
          w_valid_nxt = valid_i;
          w_state_nxt = S_RUN;
        end

        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_ctrl_nxt  = '0;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Saturating bubble counter: counts only edges that actually insert.
  assign w_bcnt_nxt = (w_insert && (r_bcnt != C_PERF_MAX)) ? (r_bcnt + C_PERF_ONE)
                                                           : r_bcnt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_valid <= w_valid_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Flush deliberately does not stall: the front end is redirected instead.
  assign stall_o      = hold_i || (r_state == S_BUBBLE) || w_req;
  assign busy_o       = (r_state != S_RUN);
  assign ctrl_o       = r_ctrl;
  assign valid_o      = r_valid;
  assign bubble_cnt_o = r_bcnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_bubble_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_bubble_stage
// Purpose  : Self-checking bench for ctrl_bubble_stage. A behavioural model
//            predicts the registered outputs for every edge; predictions are
//            queued when stimulus is driven and popped after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_bubble_stage;

  localparam int CTRL_W = 9;
  localparam int CNT_W  = 2;
  localparam int PERF_W = 4;
  localparam int C_SAT  = 15;

  logic              clk_i;
  logic              rst_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_i;
  logic              hazard_i;
  logic [CNT_W-1:0]  bubble_len_i;
  logic              flush_i;
  logic              hold_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic              valid_o;
  logic              stall_o;
  logic              busy_o;
  logic [PERF_W-1:0] bubble_cnt_o;

  ctrl_bubble_stage #(
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W),
    .PERF_W (PERF_W)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ctrl_i       (ctrl_i),
    .valid_i      (valid_i),
    .hazard_i     (hazard_i),
    .bubble_len_i (bubble_len_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .ctrl_o       (ctrl_o),
    .valid_o      (valid_o),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic [PERF_W-1:0] bcnt;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: bubbles still to insert plus a "held instruction
  // waiting to be released" flag.
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_valid;
  int                m_bcnt;
  int                m_rem;
  bit                m_rel;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl  = '0;
    m_valid = 1'b0;
    m_bcnt  = 0;
    m_rem   = 0;
    m_rel   = 1'b0;
  endtask

  task automatic model_bubble();
    m_ctrl  = '0;
    m_valid = 1'b0;
    if (m_bcnt < C_SAT) m_bcnt++;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, predict the
  // edge, then compare the registered outputs after the edge.
  task automatic cyc(input logic [CTRL_W-1:0] c, input logic v, input logic h,
                     input logic [CNT_W-1:0] bl, input logic f, input logic ho);
    bit   m_busy;
    bit   m_stall;
    int   n;
    exp_t e;
    exp_t got;
    ctrl_i       = c;
    valid_i      = v;
    hazard_i     = h;
    bubble_len_i = bl;
    flush_i      = f;
    hold_i       = ho;
    #1;
    m_busy  = (m_rem > 0) || m_rel;
    m_stall = ho || (m_rem > 0) || (!m_busy && v && h);
    chk("stall", 32'(stall_o), 32'(m_stall));
    chk("busy",  32'(busy_o),  32'(m_busy));

    if (f) begin
      m_ctrl  = '0;
      m_valid = 1'b0;
      m_rem   = 0;
      m_rel   = 1'b0;
    end else if (ho) begin
      m_rem = m_rem;
    end else if (m_rem > 0) begin
      model_bubble();
      m_rem--;
    end else if (m_rel) begin
      m_ctrl  = c;
      m_valid = v;
      m_rel   = 1'b0;
    end else if (v && h) begin
      n = (bl == 0) ? 1 : int'(bl);
      model_bubble();
      m_rem = n - 1;
      m_rel = 1'b1;
    end else begin
      m_ctrl  = c;
      m_valid = v;
    end
    e.ctrl  = m_ctrl;
    e.valid = m_valid;
    e.bcnt  = PERF_W'(m_bcnt);
    exp_q.push_back(e);

    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      chk("ctrl",  32'(ctrl_o),       32'(got.ctrl));
      chk("valid", 32'(valid_o),      32'(got.valid));
      chk("bcnt",  32'(bubble_cnt_o), 32'(got.bcnt));
    end
  endtask

  initial begin
    rst_i        = 1'b0;
    ctrl_i       = '0;
    valid_i      = 1'b0;
    hazard_i     = 1'b0;
    bubble_len_i = '0;
    flush_i      = 1'b0;
    hold_i       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ctrl",  32'(ctrl_o),       32'd0);
    chk("rst_valid", 32'(valid_o),      32'd0);
    chk("rst_bcnt",  32'(bubble_cnt_o), 32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_stall", 32'(stall_o),      32'd0);
    rst_i = 1'b1;

    // 1: plain pass-through
    cyc(9'h1A5, 1, 0, 2'd0, 0, 0);
    chk("t1_ctrl", 32'(ctrl_o), 32'h1A5);

    // 2: single bubble, then release
    cyc(9'h0C3, 1, 1, 2'd1, 0, 0);
    chk("t2_bubble", 32'(ctrl_o), 32'h0);
    cyc(9'h0C3, 1, 1, 2'd1, 0, 0);
    chk("t2_release", 32'(ctrl_o), 32'h0C3);
    chk("t2_bcnt", 32'(bubble_cnt_o), 32'd1);

    // 3: three bubbles with hazard held high through RELEASE, then len 0
    repeat (4) cyc(9'h155, 1, 1, 2'd3, 0, 0);
    chk("t3_release", 32'(ctrl_o), 32'h155);
    cyc(9'h0AA, 1, 0, 2'd0, 0, 0);
    repeat (2) cyc(9'h0F0, 1, 1, 2'd0, 0, 0);
    chk("t3_len0", 32'(ctrl_o), 32'h0F0);

    // hazard without valid: no bubble
    cyc(9'h123, 0, 1, 2'd3, 0, 0);

    // 4: flush during BUBBLE with cnt=2, then flush together with hold
    cyc(9'h111, 1, 1, 2'd3, 0, 0);
    cyc(9'h111, 1, 1, 2'd3, 1, 0);
    chk("t4_busy", 32'(busy_o), 32'd0);
    cyc(9'h022, 1, 0, 2'd0, 0, 0);
    cyc(9'h133, 1, 1, 2'd3, 0, 0);
    cyc(9'h133, 1, 1, 2'd3, 1, 1);
    cyc(9'h044, 1, 0, 2'd0, 0, 0);

    // 5: hold for four cycles inside BUBBLE
    cyc(9'h1EE, 1, 1, 2'd3, 0, 0);
    repeat (4) cyc(9'h1EE, 1, 1, 2'd3, 0, 1);
    repeat (3) cyc(9'h1EE, 1, 1, 2'd3, 0, 0);
    chk("t5_release", 32'(ctrl_o), 32'h1EE);

    // 6: saturate the 4-bit counter
    for (int i = 0; i < 6; i++) begin
      repeat (4) cyc(9'h0DD, 1, 1, 2'd3, 0, 0);
      cyc(9'h000, 0, 0, 2'd0, 0, 0);
    end
    chk("t6_sat", 32'(bubble_cnt_o), 32'hF);

    // asynchronous reset in the middle of a bubble sequence
    cyc(9'h199, 1, 1, 2'd3, 0, 0);
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("arst_ctrl",  32'(ctrl_o),       32'd0);
    chk("arst_valid", 32'(valid_o),      32'd0);
    chk("arst_bcnt",  32'(bubble_cnt_o), 32'd0);
    chk("arst_busy",  32'(busy_o),       32'd0);
    #2;
    rst_i = 1'b1;

    // random mix
    for (int i = 0; i < 300; i++) begin
      cyc(CTRL_W'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
          CNT_W'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
